adv_i2c_init_sequencer: RTL

//  Walks a register-init table after power-up and issues each entry as a single-byte
//  I2C register write to the ADV HDMI receiver (pins i2c_scl/i2c_sda).

---
 rtl/adv_i2c_init_sequencer_if.sv | 31 +++
 rtl/adv_i2c_init_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/adv_i2c_init_sequencer_if.sv
// Command/response port between the init sequencer
// and the byte-level I2C write master.
interface adv_i2c_init_sequencer_if;
  logic       i2c_cmd_valid_out;
  logic       i2c_cmd_ready_in;
  logic [6:0] i2c_cmd_dev_out;
  logic [7:0] i2c_cmd_reg_out;
  logic [7:0] i2c_cmd_data_out;
  logic       i2c_rsp_valid_in;
  logic       i2c_rsp_nack_in;

  modport master (
    output i2c_cmd_valid_out,
    output i2c_cmd_dev_out,
    output i2c_cmd_reg_out,
    output i2c_cmd_data_out,
    input  i2c_cmd_ready_in,
    input  i2c_rsp_valid_in,
    input  i2c_rsp_nack_in
  );

  modport slave (
    input  i2c_cmd_valid_out,
    input  i2c_cmd_dev_out,
    input  i2c_cmd_reg_out,
    input  i2c_cmd_data_out,
    output i2c_cmd_ready_in,
    output i2c_rsp_valid_in,
    output i2c_rsp_nack_in
  );
endinterface

// File: rtl/adv_i2c_init_sequencer.sv
// ADV receiver register-init sequencer: walks a
// {dev,reg,data} table and issues I2C writes.
module adv_i2c_init_sequencer #(
  parameter int TABLE_AW   = 8,
  parameter int CLK_HZ     = 50_000_000,
  parameter int MAX_RETRY  = 3,
  parameter int POWERUP_MS = 10
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                start_in,
  output logic [TABLE_AW-1:0] rom_addr_out,
  input  logic [23:0]         rom_data_in,
  adv_i2c_init_sequencer_if.master i2c,
  output logic                busy_out,
  output logic                done_out,
  output logic                error_out,
  output logic [TABLE_AW-1:0] err_index_out
);

  localparam int unsigned TICK =
    (CLK_HZ >= 1000) ? CLK_HZ / 1000 : 1;
  localparam int unsigned PWR_CYC = POWERUP_MS * TICK;
  localparam logic [31:0] PWR_LOAD =
    (PWR_CYC == 0) ? 32'd0 : 32'(PWR_CYC - 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);
  localparam logic [TABLE_AW-1:0] IDX_LAST = '1;

  typedef enum logic [3:0] {
    S_IDLE, S_PWRUP, S_FETCH, S_DECODE, S_ISSUE,
    S_WAIT, S_DELAY, S_DONE, S_ERROR
  } state_t;

  state_t state, state_nx, adv_tgt;

  logic [TABLE_AW-1:0] idx_q;
  logic [TABLE_AW-1:0] err_idx_q;
  logic [RW-1:0]       retry_q;
  logic [31:0]         cnt_q;
  logic [6:0]          dev_q;
  logic [7:0]          reg_q;
  logic [7:0]          dat_q;
  logic                done_q;
  logic                err_q;

  logic [7:0]  dev8;
  logic [7:0]  data8;
  logic [31:0] dly_load;
  logic is_end, is_dly, is_wr;
  logic dly_wait, dly_skip;
  logic cnt_zero, last, rest, go;
  logic rsp_ok, rsp_retry, rsp_fail, adv;

  assign dev8     = rom_data_in[23:16];
  assign data8    = rom_data_in[7:0];
  assign dly_load = 32'(data8) * 32'(TICK) - 32'd1;
  assign is_end   = dev8 == 8'h00;
  assign is_dly   = dev8 == 8'hFF;
  assign is_wr    = !is_end && !is_dly;
  assign dly_wait = is_dly && data8 != 8'h00;
  assign dly_skip = is_dly && data8 == 8'h00;
  assign cnt_zero = cnt_q == 32'd0;
  assign last     = idx_q == IDX_LAST;
  assign adv_tgt  = last ? S_ERROR : S_FETCH;

  assign rest = state == S_IDLE || state == S_DONE
             || state == S_ERROR;
  assign go   = rest && start_in;

  assign rsp_ok    = state == S_WAIT && i2c.i2c_rsp_valid_in
                  && !i2c.i2c_rsp_nack_in;
  assign rsp_retry = state == S_WAIT && i2c.i2c_rsp_valid_in
                  && i2c.i2c_rsp_nack_in && retry_q < RMAX;
  assign rsp_fail  = state == S_WAIT && i2c.i2c_rsp_valid_in
                  && i2c.i2c_rsp_nack_in && retry_q >= RMAX;
  assign adv = rsp_ok
            || (state == S_DELAY && cnt_zero)
            || (state == S_DECODE && dly_skip);

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state decision
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR:
        if (start_in) state_nx = S_PWRUP;
      S_PWRUP:
        if (cnt_zero) state_nx = S_FETCH;
      S_FETCH:
        state_nx = S_DECODE;
      S_DECODE:
        unique case (1'b1)
          is_end:   state_nx = S_DONE;
          dly_wait: state_nx = S_DELAY;
          dly_skip: state_nx = adv_tgt;
          is_wr:    state_nx = S_ISSUE;
          default:  state_nx = S_IDLE;
        endcase
      S_ISSUE:
        if (i2c.i2c_cmd_ready_in) state_nx = S_WAIT;
      S_WAIT:
        if (rsp_ok)         state_nx = adv_tgt;
        else if (rsp_retry) state_nx = S_ISSUE;
        else if (rsp_fail)  state_nx = S_ERROR;
      S_DELAY:
        if (cnt_zero) state_nx = adv_tgt;
      default:
        state_nx = S_IDLE;
    endcase
  end

  // Index, retry, timer, latched entry and status
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      idx_q     <= '0;
      err_idx_q <= '0;
      retry_q   <= '0;
      cnt_q     <= '0;
      dev_q     <= '0;
      reg_q     <= '0;
      dat_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (go) begin
        idx_q     <= '0;
        err_idx_q <= '0;
        retry_q   <= '0;
        cnt_q     <= PWR_LOAD;
        done_q    <= 1'b0;
        err_q     <= 1'b0;
      end
      if ((state == S_PWRUP || state == S_DELAY)
          && !cnt_zero)
        cnt_q <= cnt_q - 32'd1;
      if (state == S_DECODE) begin
        if (is_wr) begin
          dev_q <= dev8[7:1];
          reg_q <= rom_data_in[15:8];
          dat_q <= data8;
        end
        if (dly_wait) cnt_q <= dly_load;
        if (is_end) done_q <= 1'b1;
      end
      if (rsp_retry) retry_q <= retry_q + 1'b1;
      if (rsp_fail) begin
        err_q     <= 1'b1;
        err_idx_q <= idx_q;
      end
      if (adv) begin
        retry_q <= '0;
        if (last) begin
          err_q     <= 1'b1;
          err_idx_q <= idx_q;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

  // Moore outputs decoded from the state
  always_comb begin
    i2c.i2c_cmd_valid_out = state == S_ISSUE;
    busy_out = !rest;
  end

  assign i2c.i2c_cmd_dev_out  = dev_q;
  assign i2c.i2c_cmd_reg_out  = reg_q;
  assign i2c.i2c_cmd_data_out = dat_q;
  assign rom_addr_out  = idx_q;
  assign done_out      = done_q;
  assign error_out     = err_q;
  assign err_index_out = err_idx_q;

endmodule
